// File: rtl/sos_ctrl_module.sv
// Morse "SOS" buzzer sequencer timed from a 1 ms tick derived from CLK.
// Define SOS_REPEAT_EN to loop the word (with a WORD_MS gap) until Stop_Sig.
module sos_ctrl_module #(
    parameter logic [15:0] T1MS    = 16'd49_999,
    parameter logic [9:0]  DOT_MS  = 10'd100,
    parameter logic [9:0]  DASH_MS = 10'd300,
    parameter logic [9:0]  GAP_MS  = 10'd100,
    parameter logic [9:0]  LGAP_MS = 10'd300,
    parameter logic [9:0]  WORD_MS = 10'd700
) (
    input  logic CLK,
    input  logic RST,
    input  logic Start_Sig,
    input  logic Stop_Sig,
    output logic Pin_Out,
    output logic Busy_Sig,
    output logic Done_Sig
);

    localparam int unsigned TICK_W = 16;
    localparam int unsigned MS_W   = 10;
    localparam int unsigned IDX_W  = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(8);

`ifdef SOS_REPEAT_EN
    typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP, S_WGAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP, S_DONE} state_t;
`endif

    state_t            state;
    logic [TICK_W-1:0] Count1;
    logic [MS_W-1:0]   Count_MS;
    logic [IDX_W-1:0]  idx;

    logic              ms_tick_c;
    logic              is_dash_c;
    logic [MS_W-1:0]   phase_len_c;
    logic              phase_end_c;
    logic [TICK_W-1:0] count1_nxt_c;
    logic [MS_W-1:0]   count_ms_nxt_c;

    // Length of the current phase and the free-running tick advance
    always_comb begin
        ms_tick_c   = (Count1 == T1MS);
        is_dash_c   = (idx >= IDX_W'(3)) && (idx <= IDX_W'(5));
        phase_len_c = WORD_MS;
        case (state)
            S_TONE:  phase_len_c = is_dash_c ? DASH_MS : DOT_MS;
            S_GAP:   phase_len_c = ((idx == IDX_W'(2)) || (idx == IDX_W'(5))) ? LGAP_MS : GAP_MS;
            default: phase_len_c = WORD_MS;
        endcase
        // Count_MS counts completed ms, so the last ms of a phase sees len-1
        phase_end_c    = ms_tick_c && (Count_MS == (phase_len_c - MS_W'(1)));
        count1_nxt_c   = ms_tick_c ? '0 : (Count1 + TICK_W'(1));
        count_ms_nxt_c = ms_tick_c ? (Count_MS + MS_W'(1)) : Count_MS;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            Count1   <= '0;
            Count_MS <= '0;
            idx      <= '0;
            Pin_Out  <= 1'b0;
            Busy_Sig <= 1'b0;
            Done_Sig <= 1'b0;
        end else begin
            Done_Sig <= 1'b0;
            if ((state != S_IDLE) && Stop_Sig) begin
                state    <= S_IDLE;
                Count1   <= '0;
                Count_MS <= '0;
                Pin_Out  <= 1'b0;
                Busy_Sig <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        Count1   <= '0;
                        Count_MS <= '0;
                        if (Start_Sig && !Stop_Sig) begin
                            state    <= S_TONE;
                            idx      <= '0;
                            Pin_Out  <= 1'b1;
                            Busy_Sig <= 1'b1;
                        end
                    end
                    S_TONE: begin
                        if (phase_end_c) begin
                            Count1   <= '0;
                            Count_MS <= '0;
                            Pin_Out  <= 1'b0;
                            if (idx == LAST_IDX) begin
                                Done_Sig <= 1'b1;
`ifdef SOS_REPEAT_EN
                                state    <= S_WGAP;
`else
                                state    <= S_DONE;
                                Busy_Sig <= 1'b0;
`endif
                            end else begin
                                state <= S_GAP;
                            end
                        end else begin
                            Count1   <= count1_nxt_c;
                            Count_MS <= count_ms_nxt_c;
                        end
                    end
                    S_GAP: begin
                        if (phase_end_c) begin
                            Count1   <= '0;
                            Count_MS <= '0;
                            idx      <= idx + IDX_W'(1);
                            Pin_Out  <= 1'b1;
                            state    <= S_TONE;
                        end else begin
                            Count1   <= count1_nxt_c;
                            Count_MS <= count_ms_nxt_c;
                        end
                    end
`ifdef SOS_REPEAT_EN
                    S_WGAP: begin
                        if (phase_end_c) begin
                            Count1   <= '0;
                            Count_MS <= '0;
                            idx      <= '0;
                            Pin_Out  <= 1'b1;
                            state    <= S_TONE;
                        end else begin
                            Count1   <= count1_nxt_c;
                            Count_MS <= count_ms_nxt_c;
                        end
                    end
`else
                    S_DONE: begin
                        Count1   <= '0;
                        Count_MS <= '0;
                        state    <= S_IDLE;
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sos_ctrl_module.sv
// Directed bench for sos_ctrl_module at 4 clk/ms (T1MS=3); honours SOS_REPEAT_EN.
module tb_sos_ctrl_module;

    logic CLK = 1'b0;
    logic RST, Start_Sig, Stop_Sig;
    logic Pin_Out, Busy_Sig, Done_Sig;

    int checks = 0;
    int errors = 0;

    localparam int MAXC = 512;
`ifdef SOS_REPEAT_EN
    localparam int NRUN = 400;
`else
    localparam int NRUN = 190;
`endif

    logic pin_w [0:MAXC-1];
    logic busy_w[0:MAXC-1];
    logic done_w[0:MAXC-1];
    logic exp_pin [0:MAXC-1];
    logic exp_busy[0:MAXC-1];
    logic exp_done[0:MAXC-1];
    int   tw[9] = '{8, 8, 8, 16, 16, 16, 8, 8, 8};
    int   gw[8] = '{8, 8, 16, 8, 8, 16, 8, 8};
    int   rs[0:31];
    int   fe[0:31];
    int   npulse;

    sos_ctrl_module #(
        .T1MS(16'd3), .DOT_MS(10'd2), .DASH_MS(10'd4),
        .GAP_MS(10'd2), .LGAP_MS(10'd4), .WORD_MS(10'd6)
    ) dut (
        .CLK(CLK), .RST(RST), .Start_Sig(Start_Sig), .Stop_Sig(Stop_Sig),
        .Pin_Out(Pin_Out), .Busy_Sig(Busy_Sig), .Done_Sig(Done_Sig)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected waveform, cycle 1 = first cycle after the Start edge
    task automatic build_model();
        int t;
        int words;
        for (int c = 0; c < MAXC; c++) begin
            exp_pin[c] = 1'b0; exp_busy[c] = 1'b0; exp_done[c] = 1'b0;
        end
`ifdef SOS_REPEAT_EN
        words = 2;
`else
        words = 1;
`endif
        t = 1;
        for (int w = 0; w < words; w++) begin
            for (int i = 0; i < 9; i++) begin
                for (int k = 0; k < tw[i]; k++) begin
                    exp_pin[t] = 1'b1; exp_busy[t] = 1'b1; t++;
                end
                if (i < 8) begin
                    for (int k = 0; k < gw[i]; k++) begin
                        exp_busy[t] = 1'b1; t++;
                    end
                end
            end
            exp_done[t] = 1'b1;
`ifdef SOS_REPEAT_EN
            for (int k = 0; k < 24; k++) begin
                exp_busy[t] = 1'b1; t++;
            end
`endif
        end
    endtask

    // Start pulse, record n cycles (optional extra Start / Stop at given cycles), then abort to IDLE
    task automatic capture(input int n, input int xs, input int sp);
        Start_Sig = 1'b1;
        tick();
        Start_Sig = 1'b0;
        pin_w[0] = 1'b0; busy_w[0] = 1'b0; done_w[0] = 1'b0;
        for (int c = 1; c <= n; c++) begin
            pin_w[c] = Pin_Out; busy_w[c] = Busy_Sig; done_w[c] = Done_Sig;
            Start_Sig = (c == xs);
            Stop_Sig  = (c == sp);
            tick();
        end
        Start_Sig = 1'b0;
        Stop_Sig  = 1'b1;
        tick();
        Stop_Sig  = 1'b0;
        tick();
    endtask

    task automatic find_pulses(input int n);
        npulse = 0;
        for (int c = 1; c <= n; c++) begin
            if (pin_w[c] && !pin_w[c-1] && npulse < 32) rs[npulse] = c;
            if (!pin_w[c] && pin_w[c-1] && npulse < 32) begin
                fe[npulse] = c;
                npulse++;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; Start_Sig = 1'b0; Stop_Sig = 1'b0;
        tick(); tick();
        checks++;
        if ({Pin_Out, Busy_Sig, Done_Sig} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs got %b%b%b want 000", Pin_Out, Busy_Sig, Done_Sig);
        end
        RST = 1'b0;
        tick();
        checks++;
        if ({Pin_Out, Busy_Sig} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset got %b%b want 00", Pin_Out, Busy_Sig);
        end
    endtask

    task automatic test_first_symbols();
        capture(24, 0, 0);
        for (int c = 1; c <= 24; c++) begin
            checks++;
            if (pin_w[c] !== ((c <= 8) || (c >= 17))) begin
                errors++;
                $display("FAIL first_symbols cycle %0d pin got %b want %b", c, pin_w[c], (c <= 8) || (c >= 17));
            end
        end
        checks++;
        if (busy_w[1] !== 1'b1) begin
            errors++;
            $display("FAIL start_latency busy got %b want 1", busy_w[1]);
        end
    endtask

    task automatic test_full_run(input int xs, input string tag);
        int mp, mb, md, nb, nh, nd;
        capture(NRUN, xs, 0);
        mp = 0; mb = 0; md = 0; nb = 0; nh = 0; nd = 0;
        for (int c = 1; c <= NRUN; c++) begin
            if (pin_w[c]  !== exp_pin[c])  mp++;
            if (busy_w[c] !== exp_busy[c]) mb++;
            if (done_w[c] !== exp_done[c]) md++;
            if (c <= 200 && busy_w[c] === 1'b1) nb++;
            if (c <= 200 && pin_w[c] === 1'b1) nh++;
            if (done_w[c] === 1'b1) nd++;
        end
        checks++;
        if (mp != 0) begin errors++; $display("FAIL %s pin_waveform got %0d bad cycles want 0", tag, mp); end
        checks++;
        if (mb != 0) begin errors++; $display("FAIL %s busy_waveform got %0d bad cycles want 0", tag, mb); end
        checks++;
        if (md != 0) begin errors++; $display("FAIL %s done_waveform got %0d bad cycles want 0", tag, md); end
`ifdef SOS_REPEAT_EN
        checks++;
        if (nb != 200) begin errors++; $display("FAIL %s busy_through_wgap got %0d want 200", tag, nb); end
        checks++;
        if (nd != 2) begin errors++; $display("FAIL %s done_count got %0d want 2", tag, nd); end
        checks++;
        if ({pin_w[200], pin_w[201], done_w[377]} !== 3'b011) begin
            errors++;
            $display("FAIL %s second_word_start got %b%b%b want 011", tag, pin_w[200], pin_w[201], done_w[377]);
        end
`else
        checks++;
        if (nb != 176) begin errors++; $display("FAIL %s busy_length got %0d want 176", tag, nb); end
        checks++;
        if (nd != 1) begin errors++; $display("FAIL %s done_count got %0d want 1", tag, nd); end
        checks++;
        if ({pin_w[176], pin_w[177], busy_w[177], done_w[177]} !== 4'b1001) begin
            errors++;
            $display("FAIL %s done_alignment got %b%b%b%b want 1001", tag, pin_w[176], pin_w[177], busy_w[177], done_w[177]);
        end
`endif
        checks++;
        if (nh != 96) begin errors++; $display("FAIL %s tone_total got %0d want 96", tag, nh); end
        find_pulses(200);
        checks++;
        if (npulse != 9) begin errors++; $display("FAIL %s pulse_count got %0d want 9", tag, npulse); end
        for (int i = 0; i < 9 && i < npulse; i++) begin
            checks++;
            if (fe[i] - rs[i] != tw[i]) begin
                errors++;
                $display("FAIL %s pulse_width %0d got %0d want %0d", tag, i, fe[i] - rs[i], tw[i]);
            end
        end
    endtask

    task automatic test_letter_gap();
        capture(180, 0, 0);
        find_pulses(180);
        for (int i = 0; i < 8 && i + 1 < npulse; i++) begin
            checks++;
            if (rs[i+1] - fe[i] != gw[i]) begin
                errors++;
                $display("FAIL letter_gap %0d got %0d want %0d", i, rs[i+1] - fe[i], gw[i]);
            end
        end
    endtask

    task automatic test_stop();
        int nd;
        // 5th symbol (second dash) occupies cycles 81-96
        capture(120, 0, 88);
        checks++;
        if ({pin_w[88], busy_w[88]} !== 2'b11) begin
            errors++;
            $display("FAIL stop_pre got %b%b want 11", pin_w[88], busy_w[88]);
        end
        checks++;
        if ({pin_w[89], busy_w[89]} !== 2'b00) begin
            errors++;
            $display("FAIL stop_next_cycle got %b%b want 00", pin_w[89], busy_w[89]);
        end
        nd = 0;
        for (int c = 1; c <= 120; c++) if (done_w[c] === 1'b1 || pin_w[c] !== exp_pin[c] && c > 88 && pin_w[c] === 1'b1) nd++;
        checks++;
        if (nd != 0) begin errors++; $display("FAIL stop_no_done got %0d events want 0", nd); end
        // Stop and Start together from IDLE: Stop wins
        Start_Sig = 1'b1; Stop_Sig = 1'b1;
        tick();
        Start_Sig = 1'b0; Stop_Sig = 1'b0;
        checks++;
        if ({Pin_Out, Busy_Sig} !== 2'b00) begin
            errors++;
            $display("FAIL stop_wins got %b%b want 00", Pin_Out, Busy_Sig);
        end
        tick();
        capture(24, 0, 0);
        checks++;
        if ({pin_w[1], pin_w[8], pin_w[9], pin_w[16], pin_w[17]} !== 5'b11001) begin
            errors++;
            $display("FAIL restart_idx0 got %b%b%b%b%b want 11001", pin_w[1], pin_w[8], pin_w[9], pin_w[16], pin_w[17]);
        end
    endtask

    task automatic test_reset_mid_tone();
        Start_Sig = 1'b1;
        tick();
        Start_Sig = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({Pin_Out, Busy_Sig} !== 2'b11) begin
            errors++;
            $display("FAIL mid_tone_pre got %b%b want 11", Pin_Out, Busy_Sig);
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({Pin_Out, Busy_Sig, Done_Sig} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset got %b%b%b want 000", Pin_Out, Busy_Sig, Done_Sig);
        end
        tick();
        RST = 1'b0;
        tick();
    endtask

    initial begin
        build_model();
        test_reset();
        test_first_symbols();
        test_full_run(0, "full_run");
        test_letter_gap();
        test_full_run(85, "extra_start");
        test_stop();
        test_reset_mid_tone();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
